// File: rtl/bist_ctrl_s820.sv
// BIST controller for the s820 core: LFSR pattern source, MISR compactor, golden compare.
// Define BIST_SIG_OUT_EN to expose the live MISR value on the sig port.
module bist_ctrl_s820 #(
  parameter int unsigned PATTERNS    = 1000,
  parameter int unsigned INIT_CYCLES = 2,
  parameter logic [17:0] SEED        = 18'h00001,
  parameter logic [18:0] GOLDEN      = 19'h00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [17:0] pi,
  input  logic [18:0] po
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [18:0] sig
`endif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] INIT = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] CMP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [17:0] SEED_EFF  = (SEED == 18'h0) ? 18'h00001 : SEED;
  localparam logic [15:0] RUN_LAST  = 16'(PATTERNS - 1);
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [17:0] PI_CLEAR  = 18'h20000;

  logic [2:0]  state;
  logic [17:0] lfsr;
  logic [17:0] lfsr_next;
  logic [18:0] misr;
  logic [18:0] misr_next;
  logic [15:0] cnt;

  assign lfsr_next = {lfsr[16:0], lfsr[17] ^ lfsr[10]};
  assign misr_next = {misr[17:0], 1'b0} ^ (misr[18] ? 19'h00047 : 19'h00000) ^ po;

`ifdef BIST_SIG_OUT_EN
  assign sig = misr;
`endif

  // pi is registered one step ahead so the core sees each pattern for a full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr  <= SEED_EFF;
      misr  <= '0;
      cnt   <= '0;
      pi    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pi <= '0;
          if (start) begin
            state <= INIT;
            lfsr  <= SEED_EFF;
            misr  <= '0;
            cnt   <= '0;
            pi    <= PI_CLEAR;
            busy  <= 1'b1;
            pass  <= 1'b0;
          end
        end
        INIT: begin
          if (cnt == INIT_LAST) begin
            state <= RUN;
            cnt   <= '0;
            pi    <= lfsr;
          end else begin
            cnt <= cnt + 16'd1;
            pi  <= PI_CLEAR;
          end
        end
        RUN: begin
          misr <= misr_next;
          lfsr <= lfsr_next;
          if (cnt == RUN_LAST) begin
            state <= CMP;
            pi    <= '0;
          end else begin
            cnt <= cnt + 16'd1;
            pi  <= lfsr_next;
          end
        end
        CMP: begin
          pi    <= '0;
          pass  <= (misr == GOLDEN);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          pi <= '0;
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          pi    <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_ctrl_s820.sv
// Directed bench for bist_ctrl_s820: three instances share stimulus and differ in SEED/GOLDEN.
module tb_bist_ctrl_s820;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  poMode;

  logic        busyA, doneA, passA, busyB, doneB, passB, busyC, doneC, passC;
  logic [17:0] piA, piB, piC;
  logic [18:0] poA, poB, poC;
`ifdef BIST_SIG_OUT_EN
  logic [18:0] sigA, sigB, sigC;
`endif

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  // Stand-in for the core: mode 0 -> zeros, 1 -> constant 1, 2 -> MSB set only for pattern 1.
  function automatic logic [18:0] coreModel(input logic [17:0] p, input logic [1:0] m);
    case (m)
      2'd1:    return 19'h00001;
      2'd2:    return (p == 18'h00001) ? 19'h40000 : 19'h00000;
      default: return 19'h00000;
    endcase
  endfunction

  assign poA = coreModel(piA, poMode);
  assign poB = coreModel(piB, poMode);
  assign poC = coreModel(piC, poMode);

  bist_ctrl_s820 #(.PATTERNS(4), .INIT_CYCLES(2), .SEED(18'h00001), .GOLDEN(19'h00000)) dutA (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busyA), .done(doneA), .pass(passA),
    .pi(piA), .po(poA)
`ifdef BIST_SIG_OUT_EN
    , .sig(sigA)
`endif
  );

  bist_ctrl_s820 #(.PATTERNS(4), .INIT_CYCLES(2), .SEED(18'h00000), .GOLDEN(19'h0000F)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busyB), .done(doneB), .pass(passB),
    .pi(piB), .po(poB)
`ifdef BIST_SIG_OUT_EN
    , .sig(sigB)
`endif
  );

  bist_ctrl_s820 #(.PATTERNS(4), .INIT_CYCLES(2), .SEED(18'h00001), .GOLDEN(19'h0011C)) dutC (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busyC), .done(doneC), .pass(passC),
    .pi(piC), .po(poC)
`ifdef BIST_SIG_OUT_EN
    , .sig(sigC)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  // One full run from START; j indexes the observation after edge e0+j.
  task automatic applyStimulus(input logic [1:0] mode, input logic expA, input logic expB, input logic expC);
    logic [17:0] piExp [8];
    logic        busyExp [8];
`ifdef BIST_SIG_OUT_EN
    logic [18:0] sigExp [3][5];
    sigExp = '{'{19'h0, 19'h0, 19'h0, 19'h0, 19'h0},
               '{19'h0, 19'h1, 19'h3, 19'h7, 19'hF},
               '{19'h0, 19'h40000, 19'h47, 19'h8E, 19'h11C}};
`endif
    piExp   = '{18'h20000, 18'h20000, 18'h1, 18'h2, 18'h4, 18'h8, 18'h0, 18'h0};
    busyExp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    poMode  = mode;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checkOutput($sformatf("piA[%0d]", j), 32'(piA), 32'(piExp[j]));
      checkOutput($sformatf("busyA[%0d]", j), 32'(busyA), 32'(busyExp[j]));
      if (j == 2) checkOutput("piB_seed0_first", 32'(piB), 32'h1);
`ifdef BIST_SIG_OUT_EN
      if (j >= 2 && j <= 6) checkOutput($sformatf("sigA[%0d]", j), 32'(sigA), 32'(sigExp[mode][j-2]));
`endif
    end
    checkOutput("doneA", 32'(doneA), 32'h1);
    checkOutput("passA", 32'(passA), 32'(expA));
    checkOutput("passB", 32'(passB), 32'(expB));
    checkOutput("passC", 32'(passC), 32'(expC));
  endtask

  task automatic releaseStart();
    start = 1'b0;
    @(negedge clk);
    checkOutput("doneDrop", 32'(doneA), 32'h0);
    checkOutput("piIdle", 32'(piA), 32'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b1;
    poMode = 2'd0;
    repeat (3) @(negedge clk);
    checkOutput("rstPi", 32'(piA), 32'h0);
    checkOutput("rstBusy", 32'(busyA), 32'h0);
    checkOutput("rstDone", 32'(doneA), 32'h0);
    checkOutput("rstPass", 32'(passA), 32'h0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idleBusy", 32'(busyA), 32'h0);

    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("holdDone", 32'(doneA), 32'h1);
    checkOutput("holdBusy", 32'(busyA), 32'h0);
    checkOutput("holdPass", 32'(passA), 32'h1);
    releaseStart();
    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0);
    releaseStart();

    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0);
    releaseStart();
    applyStimulus(2'd2, 1'b0, 1'b0, 1'b1);
    releaseStart();

    // Abort during RUN pattern 2, then confirm a clean rerun.
    poMode = 2'd0;
    start  = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    checkOutput("midPi", 32'(piA), 32'h2);
    rst_n = 1'b0;
    #1;
    checkOutput("abortPi", 32'(piA), 32'h0);
    checkOutput("abortBusy", 32'(busyA), 32'h0);
    checkOutput("abortDone", 32'(doneA), 32'h0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postAbortBusy", 32'(busyA), 32'h0);
    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0);
    releaseStart();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bist_ctrl_s820.md
# bist_ctrl_s820

Built-in self-test controller for the s820 sequential benchmark core. It drives all 18 primary inputs of the core from a pseudo-random pattern generator and first forces the core's 5-flop state to zero through its G18 clear input. It compacts the 19 primary outputs into a signature register and compares the result against a golden value. It sits beside the core in the test wrapper and is started and polled by the test host over a level handshake.

## Interface
- PATTERNS, 1000, number of RUN cycles (1..65535).
- INIT_CYCLES, 2, number of cycles G18 is held high before RUN (1..15).
- SEED, 18'h00001, LFSR load value; a value of 0 is replaced by 18'h00001.
- GOLDEN, 19'h00000, expected final MISR value.
- CK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  level request from host.
- BUSY  output  1  high in INIT, RUN and CMP.
- DONE  output  1  high in DONE state.
- PASS  output  1  compare result; valid while DONE is high.
- PI  output  18  to the core, order {G18,G16..G0}; PI[17] drives G18.
- PO  input  19  from the core, fixed order {G290,G327,G47,G55,G288,G296,G310,G312,G325,G300,G43,G53,G298,G315,G322,G49,G45,G292,G302}.
- SIG  output  19  live MISR value; present only with BIST_SIG_OUT_EN.

## Operation
- States: IDLE, INIT, RUN, CMP, DONE.
- IDLE -> INIT when START=1 is sampled. In INIT, LFSR<=SEED, MISR<=0, and counter<=0 on the entry edge.
- INIT: PI=18'h20000 (G18=1, all others 0). Lasts INIT_CYCLES cycles, then -> RUN.
- RUN: PI=LFSR. On each edge:
  - MISR<=next(MISR,PO).
  - LFSR advances.
  - counter increments.
  - After PATTERNS edges -> CMP.
- CMP: one cycle. PI=0. PASS<=(MISR==GOLDEN). -> DONE.
- DONE: DONE=1, PASS held. -> IDLE when START=0 is sampled. START held high keeps the block in DONE; no re-run occurs.
- START changes during INIT, RUN or CMP are ignored.
- LFSR: Fibonacci, next = {L[16:0], L[17]^L[10]} (x^18+x^11+1, maximal length).
- MISR: Galois, next = {M[17:0],1'b0} ^ (M[18] ? 19'h00047 : 0) ^ PO (x^19+x^6+x^2+x+1).
- Counter: 16-bit, no wrap. Terminal count is PATTERNS-1 during RUN.
- IDLE and DONE: PI=0, LFSR and MISR hold their values.

## Timing
- Reset (RST_N=0, asynchronous): state=IDLE, PI=0, BUSY=0, DONE=0, PASS=0, LFSR=SEED (0 mapped to 1), MISR=0, counter=0. SIG=0 when compiled in.
- Reset asserted mid-run aborts immediately. No partial result is retained. A new START is required after reset release.
- Latency: START sampled at edge e0 gives:
  - BUSY=1 after e0.
  - RUN entered at e0+INIT_CYCLES.
  - CMP entered at e0+INIT_CYCLES+PATTERNS.
  - DONE=1 and PASS valid after e0+INIT_CYCLES+PATTERNS+1.
- PO is sampled at the same edge that ends the cycle in which the matching PI pattern was applied. The core's output logic is combinational, so no pipeline skew is modelled.
- All outputs are registered. None are combinational from START or PO.

## Configuration
- BIST_SIG_OUT_EN defined: the SIG port exists and is driven by the MISR register, updating as described above.
- BIST_SIG_OUT_EN undefined: the SIG port is absent. Only PASS reports the result. All other behaviour is identical.

## Test plan
- Reset: hold RST_N=0 for 3 cycles with START=1 -> PI=0, BUSY=0, DONE=0, PASS=0; no state change until release.
- PATTERNS=4, INIT_CYCLES=2, SEED=1, PO tied to 0, GOLDEN=0, START at e0:
  - PI=18'h20000 for 2 cycles, then 1, 2, 4, 8.
  - DONE=1 after e0+7, PASS=1.
  - BUSY high for exactly 7 cycles.
- Same setup with PO tied to 19'h00001 and BIST_SIG_OUT_EN on: SIG steps 0 -> 1 -> 3 -> 7 -> F. With GOLDEN=0, PASS=0; with GOLDEN=19'h0000F, PASS=1.
- START held high through DONE for 10 cycles -> the block stays in DONE. Drop START -> IDLE on the next edge. Raise START again -> a new run with identical PI sequence and PASS.
- RST_N pulsed low during RUN pattern 2 -> outputs clear immediately, state=IDLE. A following run matches a clean run bit-for-bit.
- SEED=0 -> the first RUN pattern is 18'h00001. MISR feedback check: a PO sequence that sets M[18] yields an XOR with 19'h00047 on the next edge.
